// File: rtl/ysyx_22041752_rf_mp_if.sv
// Register-file port bundle: read ports, write ports, scoreboard alloc/flush and busy count.
// Parameters must match those of the ysyx_22041752_rf_mp instance it connects to.
interface ysyx_22041752_rf_mp_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 64,
  parameter int unsigned NR = 4,
  parameter int unsigned NW = 2
);
  logic [NR*AW-1:0] addr_r;
  logic [NR*DW-1:0] data_r;
  logic [NR-1:0]    busy_r;
  logic [NW-1:0]    we;
  logic [NW*AW-1:0] addr_w;
  logic [NW*DW-1:0] data_w;
  logic             alloc_valid;
  logic [AW-1:0]    alloc_addr;
  logic             flush;
  logic [AW:0]      busy_cnt;

  modport master (
    output addr_r, we, addr_w, data_w, alloc_valid, alloc_addr, flush,
    input  data_r, busy_r, busy_cnt
  );

  modport slave (
    input  addr_r, we, addr_w, data_w, alloc_valid, alloc_addr, flush,
    output data_r, busy_r, busy_cnt
  );
endinterface

// File: rtl/ysyx_22041752_rf_mp.sv
// Multi-port integer register file with per-register busy scoreboard for the dual-issue core.
// Define YSYX_22041752_RF_BYPASS_EN for same-cycle write-to-read bypass on the read ports.
module ysyx_22041752_rf_mp #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 64,
  parameter int unsigned NR = 4,
  parameter int unsigned NW = 2
) (
  input logic                  clk,
  input logic                  reset,
  ysyx_22041752_rf_mp_if.slave bus
);

  localparam int unsigned NREG = 2 ** AW;
  localparam int unsigned CW   = AW + 1;

  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [CW-1:0]   n_set;
  logic [CW-1:0]   n_clr;

  logic [NR*DW-1:0] data_r_c;
  logic [NR-1:0]    busy_r_c;
  logic [AW-1:0]    ra;

  // Next state: writes in ascending port order so the highest index wins; alloc beats release; flush beats all.
  always_comb begin : next_state
    regs_d = regs_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;
    n_set  = '0;
    n_clr  = '0;
    for (int w = 0; w < NW; w++) begin
      if (bus.we[w] && (bus.addr_w[w*AW +: AW] != '0)) begin
        regs_d[bus.addr_w[w*AW +: AW]] = bus.data_w[w*DW +: DW];
        busy_d[bus.addr_w[w*AW +: AW]] = 1'b0;
      end
    end
    if (bus.alloc_valid && (bus.alloc_addr != '0)) begin
      busy_d[bus.alloc_addr] = 1'b1;
    end
    if (bus.flush) begin
      busy_d = '0;
    end
    for (int i = 0; i < NREG; i++) begin
      if (busy_d[i] && !busy_q[i]) n_set = n_set + CW'(1);
      if (!busy_d[i] && busy_q[i]) n_clr = n_clr + CW'(1);
    end
    cnt_d = bus.flush ? '0 : (cnt_q + n_set - n_clr);
  end

  always_ff @(posedge clk) begin : state_reg
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Read ports: x0 is hard zero and never busy.
  always_comb begin : read_ports
    data_r_c = '0;
    busy_r_c = '0;
    ra       = '0;
    for (int k = 0; k < NR; k++) begin
      ra = bus.addr_r[k*AW +: AW];
      if (ra != '0) begin
        data_r_c[k*DW +: DW] = regs_q[ra];
        busy_r_c[k]          = busy_q[ra];
`ifdef YSYX_22041752_RF_BYPASS_EN
        for (int w = 0; w < NW; w++) begin
          if (bus.we[w] && (bus.addr_w[w*AW +: AW] == ra)) begin
            data_r_c[k*DW +: DW] = bus.data_w[w*DW +: DW];
            busy_r_c[k]          = bus.alloc_valid && (bus.alloc_addr == ra);
          end
        end
`endif
      end
    end
  end

  assign bus.data_r   = data_r_c;
  assign bus.busy_r   = busy_r_c;
  assign bus.busy_cnt = cnt_q;

endmodule
